// File: rtl/exe_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : exe_mul_unit
// Purpose  : Multi-cycle MUL/MLA execute unit for the EX stage. It selects
//            forwarded operands, runs an iterative shift-add multiply that
//            retires BPC multiplier bits per cycle, and stalls the pipeline
//            while it runs. It also owns the {N,Z,C,V} status register, which
//            is written by single-cycle ALU ops or by a completing multiply.
// Ports    : clk, rst (sync, active-low)
//            in_valid, mul_en, mla_en, s_en, flush   - instruction controls
//            sel_src1/2/3                            - Rn/Rm/Rs forward selects
//            val_rn/rm/rs, alu_res_fwd, wb_res_fwd   - operand sources
//            alu_status                              - ALU {N,Z,C,V}
//            stall, mul_valid, mul_res, status_out, busy - results/handshake
// Revision : 1.0 - initial release
// ============================================================================
module exe_mul_unit #(
  parameter int DW  = 32,
  parameter int BPC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          mul_en,
  input  logic          mla_en,
  input  logic          s_en,
  input  logic          flush,
  input  logic [1:0]    sel_src1,
  input  logic [1:0]    sel_src2,
  input  logic [1:0]    sel_src3,
  input  logic [DW-1:0] val_rn,
  input  logic [DW-1:0] val_rm,
  input  logic [DW-1:0] val_rs,
  input  logic [DW-1:0] alu_res_fwd,
  input  logic [DW-1:0] wb_res_fwd,
  input  logic [3:0]    alu_status,
  output logic          stall,
  output logic          mul_valid,
  output logic [DW-1:0] mul_res,
  output logic [3:0]    status_out,
  output logic          busy
);

  localparam int N_IT = DW / BPC;
  localparam int CW   = $clog2(N_IT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [DW-1:0] mcand;
  logic [DW-1:0] mplier;
  logic [DW-1:0] acc;
  logic [DW-1:0] res_hold;
  logic [CW-1:0] cnt;
  logic [3:0]    status;

  logic [DW-1:0] src1;
  logic [DW-1:0] src2;
  logic [DW-1:0] src3;
  logic [DW-1:0] partial;
  logic          start;
  logic          last_it;
  logic          mul_flag_wr;

  function automatic logic [DW-1:0] fwd_sel(input logic [1:0]    sel,
                                            input logic [DW-1:0] reg_val,
                                            input logic [DW-1:0] alu_val,
                                            input logic [DW-1:0] wb_val);
    case (sel)
      2'b01:   fwd_sel = alu_val;
      2'b10:   fwd_sel = wb_val;
      default: fwd_sel = reg_val;
    endcase
  endfunction

  assign src1 = fwd_sel(sel_src1, val_rn, alu_res_fwd, wb_res_fwd);
  assign src2 = fwd_sel(sel_src2, val_rm, alu_res_fwd, wb_res_fwd);
  assign src3 = fwd_sel(sel_src3, val_rs, alu_res_fwd, wb_res_fwd);

  assign start   = in_valid & mul_en & ~flush & (state == IDLE);
  assign last_it = (cnt == CW'(N_IT - 1));

  // One partial product per cycle: multiplicand times the low BPC multiplier
  // bits; the product is only needed modulo 2^DW.
  assign partial = mcand * DW'(mplier[BPC-1:0]);

  // Result is visible during DONE straight from the accumulator, and held
  // afterwards so mul_res keeps the last completed value.
  assign mul_res    = (state == DONE) ? acc : res_hold;
  assign status_out = status;

  // A completing, unflushed multiply with S set owns the flag write.
  assign mul_flag_wr = (state == DONE) & ~flush & s_en;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    mul_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        stall = start;
        if (start) begin
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        busy  = 1'b1;
        stall = ~flush;
        if (flush) begin
          state_nxt = IDLE;
        end else if (last_it) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        mul_valid = ~flush;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      res_hold <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mcand  <= src2;
            mplier <= src3;
            acc    <= mla_en ? src1 : '0;
            cnt    <= '0;
          end
        end
        BUSY: begin
          if (!flush) begin
            acc    <= acc + partial;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
            cnt    <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (!flush) begin
            res_hold <= acc;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      status <= 4'b0000;
    end else if (mul_flag_wr) begin
      status <= {acc[DW-1], (acc == '0), status[1:0]};
    end else if (in_valid & ~mul_en & s_en & ~stall) begin
      status <= alu_status;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exe_mul_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_mul_unit
// Purpose  : Self-checking bench for exe_mul_unit. Two instances (BPC=1 and
//            BPC=4, DW=32) share operand inputs but have separate in_valid.
//            A behavioural model predicts every output each cycle; directed
//            operations add hand-computed literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_mul_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv1, iv4;
  logic        mul_en, mla_en, s_en, flush;
  logic [1:0]  sel1, sel2, sel3;
  logic [31:0] val_rn, val_rm, val_rs, alu_fwd, wb_fwd;
  logic [3:0]  alu_status;

  logic        stall1, mv1, busy1, stall4, mv4, busy4;
  logic [31:0] res1, res4;
  logic [3:0]  st1, st4;

  int checks = 0;
  int errors = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  exe_mul_unit #(.DW(32), .BPC(1)) u_bpc1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .mul_en(mul_en), .mla_en(mla_en),
    .s_en(s_en), .flush(flush), .sel_src1(sel1), .sel_src2(sel2), .sel_src3(sel3),
    .val_rn(val_rn), .val_rm(val_rm), .val_rs(val_rs), .alu_res_fwd(alu_fwd),
    .wb_res_fwd(wb_fwd), .alu_status(alu_status), .stall(stall1), .mul_valid(mv1),
    .mul_res(res1), .status_out(st1), .busy(busy1));

  exe_mul_unit #(.DW(32), .BPC(4)) u_bpc4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .mul_en(mul_en), .mla_en(mla_en),
    .s_en(s_en), .flush(flush), .sel_src1(sel1), .sel_src2(sel2), .sel_src3(sel3),
    .val_rn(val_rn), .val_rm(val_rm), .val_rs(val_rs), .alu_res_fwd(alu_fwd),
    .wb_res_fwd(wb_fwd), .alu_status(alu_status), .stall(stall4), .mul_valid(mv4),
    .mul_res(res4), .status_out(st4), .busy(busy4));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mk = -1 when idle, otherwise number of iteration cycles already spent;
  // mk == NIT means the result cycle.
  int          nit [2] = '{32, 8};
  int          mk  [2] = '{-1, -1};
  logic [31:0] mpend [2];
  logic [31:0] mhold [2];
  logic [3:0]  mstat [2];

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r);
    if (s == 2'b01) return alu_fwd;
    if (s == 2'b10) return wb_fwd;
    return r;
  endfunction

  function automatic logic ivld(input int i);
    return (i == 0) ? iv1 : iv4;
  endfunction

  function automatic logic f_stall(input int i);
    if (mk[i] < 0) return ivld(i) & mul_en & ~flush;
    if (mk[i] < nit[i]) return ~flush;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic mw;
      logic st;
      mw = 1'b0;
      st = f_stall(i);
      if (!rst) begin
        mk[i]    <= -1;
        mhold[i] <= 32'h0;
        mstat[i] <= 4'h0;
      end else begin
        if (mk[i] < 0) begin
          if (ivld(i) & mul_en & ~flush) begin
            mk[i]    <= 0;
            mpend[i] <= fwd(sel2, val_rm) * fwd(sel3, val_rs)
                        + (mla_en ? fwd(sel1, val_rn) : 32'h0);
          end
        end else if (mk[i] < nit[i]) begin
          mk[i] <= flush ? -1 : mk[i] + 1;
        end else begin
          mk[i] <= -1;
          if (!flush) begin
            mhold[i] <= mpend[i];
            if (s_en) begin
              mw = 1'b1;
              mstat[i] <= {mpend[i][31], (mpend[i] == 32'h0), mstat[i][1:0]};
            end
          end
        end
        if (!mw && ivld(i) && !mul_en && s_en && !st) mstat[i] <= alu_status;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        logic        e_valid;
        logic [31:0] e_res;
        e_valid = (mk[i] == nit[i]) & ~flush;
        e_res   = (mk[i] == nit[i]) ? mpend[i] : mhold[i];
        if (i == 0) begin
          chk("m1_stall",  {31'h0, stall1}, {31'h0, f_stall(0)});
          chk("m1_valid",  {31'h0, mv1},    {31'h0, e_valid});
          chk("m1_busy",   {31'h0, busy1},  {31'h0, (mk[0] >= 0)});
          chk("m1_res",    res1,            e_res);
          chk("m1_status", {28'h0, st1},    {28'h0, mstat[0]});
        end else begin
          chk("m4_stall",  {31'h0, stall4}, {31'h0, f_stall(1)});
          chk("m4_valid",  {31'h0, mv4},    {31'h0, e_valid});
          chk("m4_busy",   {31'h0, busy4},  {31'h0, (mk[1] >= 0)});
          chk("m4_res",    res4,            e_res);
          chk("m4_status", {28'h0, st4},    {28'h0, mstat[1]});
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    iv1 = 0; iv4 = 0; mul_en = 0; mla_en = 0; s_en = 0; flush = 0;
  endtask

  task automatic alu_op(input logic [3:0] f);
    @(posedge clk); #1;
    iv1 = 1; iv4 = 1; mul_en = 0; s_en = 1; alu_status = f;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic run_op(input int which, input logic mla, input logic s,
                        input logic [31:0] rn, input logic [31:0] rm, input logic [31:0] rs,
                        input logic [1:0] s1, input logic [1:0] s2, input logic [1:0] s3,
                        input logic [31:0] af, input logic [31:0] wf,
                        input int flush_at, input logic mid_chg,
                        output int stall_cnt, output int valid_cyc);
    int n;
    n = (which == 0) ? 32 : 8;
    @(posedge clk); #1;
    val_rn = rn; val_rm = rm; val_rs = rs; sel1 = s1; sel2 = s2; sel3 = s3;
    alu_fwd = af; wb_fwd = wf; mla_en = mla; s_en = s; mul_en = 1; flush = 0;
    iv1 = (which == 0); iv4 = (which == 1);
    stall_cnt = 0; valid_cyc = 0;
    for (int i = 1; i <= n + 2; i++) begin
      @(negedge clk);
      if ((which == 0) ? stall1 : stall4) stall_cnt++;
      if ((which == 0) ? mv1 : mv4) valid_cyc = i;
      @(posedge clk); #1;
      if (mid_chg && i == 5) begin
        alu_fwd = 32'd100; wb_fwd = 32'd100; val_rm = 32'd99; val_rs = 32'd99;
      end
      if (flush_at != 0 && i == flush_at) begin
        flush = 1; iv1 = 0; iv4 = 0;
      end
      if (flush_at != 0 && i == flush_at + 1) break;
    end
    idle_inputs();
  endtask

  initial begin
    int sc, vc;
    rst = 0;
    idle_inputs();
    sel1 = 0; sel2 = 0; sel3 = 0;
    val_rn = 0; val_rm = 0; val_rs = 0; alu_fwd = 0; wb_fwd = 0; alu_status = 0;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1;
    @(negedge clk);
    chk("rst_status", {28'h0, st1}, 32'h0);
    chk("rst_res",    res1, 32'h0);
    chk("rst_busy",   {31'h0, busy1}, 32'h0);
    @(posedge clk); #1;
    rst = 1;

    // MUL 3*5, S set
    run_op(0, 0, 1, 0, 3, 5, 0, 0, 0, 0, 0, 0, 0, sc, vc);
    chk("mul_stall_cycles", sc, 33);
    chk("mul_valid_cycle",  vc, 34);
    @(negedge clk);
    chk("mul_res_15", res1, 32'd15);
    chk("mul_nz_00",  {30'h0, st1[3:2]}, 32'h0);

    // MLA 0xFFFFFFFF*2 + 3, C,V preloaded
    alu_op(4'b0011);
    run_op(0, 1, 1, 3, 32'hFFFF_FFFF, 2, 0, 0, 0, 0, 0, 0, 0, sc, vc);
    @(negedge clk);
    chk("mla_res",    res1, 32'h0000_0001);
    chk("mla_status", {28'h0, st1}, 32'h3);

    // MUL 0*7 with and without S
    alu_op(4'b0011);
    run_op(0, 0, 1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, sc, vc);
    @(negedge clk);
    chk("zero_s1_status", {28'h0, st1}, 32'h7);
    alu_op(4'b0011);
    run_op(0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, sc, vc);
    @(negedge clk);
    chk("zero_s0_status", {28'h0, st1}, 32'h3);

    // forwarded operands, changed mid-operation
    run_op(0, 0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, 6, 7, 0, 1, sc, vc);
    @(negedge clk);
    chk("fwd_res_42", res1, 32'd42);

    // flush during the tenth iteration cycle
    alu_op(4'b1001);
    run_op(0, 0, 1, 0, 9, 9, 0, 0, 0, 0, 0, 10, 0, sc, vc);
    chk("flush_no_valid", vc, 0);
    chk("flush_stall_cycles", sc, 10);
    @(negedge clk);
    chk("flush_busy",   {31'h0, busy1}, 32'h0);
    chk("flush_status", {28'h0, st1}, 32'h9);
    chk("flush_res_hold", res1, 32'd42);

    // reset in the middle of an operation
    alu_op(4'b1010);
    @(posedge clk); #1;
    val_rm = 5; val_rs = 5; sel2 = 0; sel3 = 0; mul_en = 1; iv1 = 1;
    repeat (6) @(posedge clk);
    #1;
    rst = 0; idle_inputs();
    @(posedge clk); #1;
    rst = 1;
    @(negedge clk);
    chk("rstmid_stall",  {31'h0, stall1}, 32'h0);
    chk("rstmid_valid",  {31'h0, mv1}, 32'h0);
    chk("rstmid_busy",   {31'h0, busy1}, 32'h0);
    chk("rstmid_res",    res1, 32'h0);
    chk("rstmid_status", {28'h0, st1}, 32'h0);

    // four bits per cycle
    run_op(1, 0, 0, 0, 32'h1234, 32'h100, 0, 0, 0, 0, 0, 0, 0, sc, vc);
    chk("bpc4_stall_cycles", sc, 9);
    chk("bpc4_valid_cycle",  vc, 10);
    @(negedge clk);
    chk("bpc4_res", res4, 32'h0012_3400);

    repeat (3) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
